// File: rtl/rx_ber_checker_pkg.sv
// Shared types and defaults for the rx_ber_checker slice: FSM state encoding,
// PRBS9 history length, search window size and lock threshold.
package rx_ber_checker_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        COUNT  = 1'b1
    } state_t;

    localparam int DEF_PRBS_LEN = 511;
    localparam int DEF_WINDOW   = 128;
    localparam int DEF_LOCK_THR = 4;

    // Next candidate delay, wrapping from the last history tap back to 0.
    function automatic logic [8:0] next_delay(input logic [8:0] d, input logic [8:0] d_max);
        return (d == d_max) ? 9'd0 : d + 9'd1;
    endfunction

endpackage

// File: rtl/rx_ber_checker_if.sv
// Datapath/status bundle of one rx_ber_checker branch (I or Q).
// master = control/source side, slave = checker side.
interface rx_ber_checker_if #(
    parameter int NBT_IN = 8,
    parameter int OS     = 4,
    parameter int NB_CNT = 64
);
    localparam int PW = $clog2(OS);

    logic                     i_enable;
    logic [PW-1:0]            i_phase_cnt;
    logic [PW-1:0]            i_phase_sel;
    logic signed [NBT_IN-1:0] i_sample;
    logic                     i_ref_bit;

    logic                     o_rx_bit;
    logic                     o_rx_valid;
    logic                     o_locked;
    logic [8:0]               o_latency;
    logic [NB_CNT-1:0]        o_bit_count;
    logic [NB_CNT-1:0]        o_err_count;

    modport master (
        output i_enable, i_phase_cnt, i_phase_sel, i_sample, i_ref_bit,
        input  o_rx_bit, o_rx_valid, o_locked, o_latency, o_bit_count, o_err_count
    );

    modport slave (
        input  i_enable, i_phase_cnt, i_phase_sel, i_sample, i_ref_bit,
        output o_rx_bit, o_rx_valid, o_locked, o_latency, o_bit_count, o_err_count
    );

endinterface

// File: rtl/rx_ber_checker_decim.sv
// rx_decim_slicer: picks one sample per symbol at the selected phase and
// slices it on its sign bit; rx_valid pulses the cycle after the strobe.
module rx_decim_slicer #(
    parameter int NBT_IN = 8,
    parameter int OS     = 4
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic [$clog2(OS)-1:0]    i_phase_cnt,
    input  logic [$clog2(OS)-1:0]    i_phase_sel,
    input  logic signed [NBT_IN-1:0] i_sample,
    output logic                     strobe,
    output logic                     rx_bit,
    output logic                     rx_valid
);

    // Only the sign matters to the slicer; magnitude bits are intentionally dropped.
    logic unused_mag;
    assign unused_mag = ^i_sample[NBT_IN-2:0];

    assign strobe = i_enable && (i_phase_cnt == i_phase_sel);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            rx_bit   <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= strobe;
            if (strobe) rx_bit <= i_sample[NBT_IN-1];
        end
    end

endmodule

// File: rtl/rx_ber_checker.sv
// rx_ber_checker top: decimation/slicing, PRBS reference history, delay search
// FSM and saturating BER counters. Optional macro RX_BER_AUTO_RELOCK_EN.
module rx_ber_checker
    import rx_ber_checker_pkg::*;
#(
    parameter int NBT_IN   = 8,
    parameter int OS       = 4,
    parameter int NB_CNT   = 64,
    parameter int PRBS_LEN = DEF_PRBS_LEN,
    parameter int WINDOW   = DEF_WINDOW,
    parameter int LOCK_THR = DEF_LOCK_THR
) (
    input  logic           clk,
    input  logic           i_reset,
    rx_ber_checker_if.slave bus
);

    localparam int WCW = $clog2(WINDOW);
    localparam int WEW = $clog2(WINDOW + 1);
    localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW - 1);
    localparam logic [WEW-1:0] THR      = WEW'(LOCK_THR);
    localparam logic [8:0]     DLY_MAX  = 9'(PRBS_LEN - 1);

    logic                strobe;
    logic                rx_bit;
    logic                rx_valid;
    logic [PRBS_LEN-1:0] hist;
    state_t              state;
    logic [8:0]          delay;
    logic [WCW-1:0]      win_cnt;
    logic [WEW-1:0]      win_err;
    logic [WEW-1:0]      win_total;
    logic                err;
    logic                locked;
    logic [8:0]          latency;
    logic [NB_CNT-1:0]   bit_count;
    logic [NB_CNT-1:0]   err_count;

    rx_decim_slicer #(.NBT_IN(NBT_IN), .OS(OS)) u_decim (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_enable    (bus.i_enable),
        .i_phase_cnt (bus.i_phase_cnt),
        .i_phase_sel (bus.i_phase_sel),
        .i_sample    (bus.i_sample),
        .strobe      (strobe),
        .rx_bit      (rx_bit),
        .rx_valid    (rx_valid)
    );

    // NOTE: the history is a plain shift register, not a RAM, so it can and
    // must be cleared by reset; a stale history would bias the first window.
    always_ff @(posedge clk) begin
        if (!i_reset)    hist <= '0;
        else if (strobe) hist <= {hist[PRBS_LEN-2:0], bus.i_ref_bit};
    end

    assign err       = rx_bit ^ hist[delay];
    assign win_total = win_err + WEW'(err);

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state     <= SEARCH;
            delay     <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            latency   <= '0;
            bit_count <= '0;
            err_count <= '0;
        end else if (rx_valid) begin
            case (state)
                SEARCH: begin
                    if (win_cnt == WIN_LAST) begin
                        win_cnt <= '0;
                        win_err <= '0;
                        if (win_total <= THR) begin
                            state   <= COUNT;
                            locked  <= 1'b1;
                            latency <= delay;
                        end else begin
                            delay <= next_delay(delay, DLY_MAX);
                        end
                    end else begin
                        win_cnt <= win_cnt + WCW'(1);
                        win_err <= win_total;
                    end
                end
                COUNT: begin
                    if (bit_count != '1)        bit_count <= bit_count + NB_CNT'(1);
                    if (err && err_count != '1) err_count <= err_count + NB_CNT'(1);
`ifdef RX_BER_AUTO_RELOCK_EN
                    // Monitor link quality per window; a burst of errors restarts the search.
                    if (win_cnt == WIN_LAST) begin
                        win_cnt <= '0;
                        win_err <= '0;
                        if (win_total > WEW'(4 * LOCK_THR)) begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                            delay  <= next_delay(delay, DLY_MAX);
                        end
                    end else begin
                        win_cnt <= win_cnt + WCW'(1);
                        win_err <= win_total;
                    end
`endif
                end
                default: state <= SEARCH;
            endcase
        end
    end

    assign bus.o_rx_bit    = rx_bit;
    assign bus.o_rx_valid  = rx_valid;
    assign bus.o_locked    = locked;
    assign bus.o_latency   = latency;
    assign bus.o_bit_count = bit_count;
    assign bus.o_err_count = err_count;

endmodule

// File: tb/tb_rx_ber_checker.sv
// Directed self-checking bench for rx_ber_checker: lock search, BER counting,
// enable freeze, reset, mis-phased sampling and (if compiled) auto relock.
module tb_rx_ber_checker;

    logic clk = 1'b0;
    logic i_reset = 1'b0;

    rx_ber_checker_if #(.NBT_IN(8), .OS(4), .NB_CNT(64)) bus ();

    rx_ber_checker #(.NBT_IN(8), .OS(4), .NB_CNT(64)) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [8:0]  lfsr;
    logic [15:0] tdl;
    int          dly;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_rx_bit"},  64'(bus.o_rx_bit),   64'd0);
        check({tag, "_valid"},   64'(bus.o_rx_valid), 64'd0);
        check({tag, "_locked"},  64'(bus.o_locked),   64'd0);
        check({tag, "_latency"}, 64'(bus.o_latency),  64'd0);
        check({tag, "_bits"},    bus.o_bit_count,     64'd0);
        check({tag, "_errs"},    bus.o_err_count,     64'd0);
    endtask

    // One symbol: next PRBS9 bit as reference, reference delayed by dly symbols
    // (optionally inverted) as the data at data_ph; other phases random if noisy.
    task automatic sym(input bit flip, input bit noisy, input int data_ph);
        logic       nb;
        logic       rb;
        logic [7:0] s;
        nb   = lfsr[8];
        lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        tdl  = {tdl[14:0], nb};
        rb   = tdl[dly] ^ flip;
        s    = rb ? 8'hC0 : 8'h40;
        for (int ph = 0; ph < 4; ph++) begin
            @(negedge clk);
            bus.i_phase_cnt = 2'(ph);
            bus.i_ref_bit   = nb;
            bus.i_sample    = (noisy && ph != data_ph) ? 8'($urandom) : s;
        end
    endtask

    initial begin
        int   vcount;
        logic [63:0] e_exp;
        bus.i_enable    = 1'b1;
        bus.i_phase_sel = 2'd2;
        bus.i_phase_cnt = 2'd0;
        bus.i_sample    = 8'h00;
        bus.i_ref_bit   = 1'b0;
        lfsr = 9'h1AA;
        tdl  = '0;
        dly  = 7;

        repeat (3) @(negedge clk);
        check_cleared("reset");
        i_reset = 1'b1;

        // Delay candidates 0..6 fail; the window at delay 7 ends on symbol 1024.
        repeat (1023) sym(1'b0, 1'b0, 2);
        @(negedge clk);
        check("no_lock_at_1023", 64'(bus.o_locked), 64'd0);
        sym(1'b0, 1'b0, 2);
        @(negedge clk);
        check("lock",         64'(bus.o_locked),  64'd1);
        check("latency_7",    64'(bus.o_latency), 64'd7);
        check("bits_at_lock", bus.o_bit_count,    64'd0);

        repeat (300) sym(1'b0, 1'b0, 2);
        @(negedge clk);
        check("bits_300", bus.o_bit_count, 64'd300);
        check("errs_0",   bus.o_err_count, 64'd0);

        for (int i = 1; i <= 250; i++) sym(i % 100 == 0, 1'b0, 2);
        @(negedge clk);
        check("bits_550", bus.o_bit_count, 64'd550);
        check("errs_2",   bus.o_err_count, 64'd2);

        @(negedge clk);
        bus.i_enable = 1'b0;
        vcount = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.o_rx_valid) vcount++;
            bus.i_phase_cnt = 2'(c % 4);
            bus.i_sample    = 8'($urandom);
        end
        check("disabled_valids", 64'(vcount),        64'd0);
        check("disabled_bits",   bus.o_bit_count,    64'd550);
        check("disabled_errs",   bus.o_err_count,    64'd2);
        check("disabled_lat",    64'(bus.o_latency), 64'd7);
        check("disabled_locked", 64'(bus.o_locked),  64'd1);
        bus.i_enable = 1'b1;

        repeat (20) sym(1'b0, 1'b0, 2);
        @(negedge clk);
        check("bits_570", bus.o_bit_count, 64'd570);

        @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        check_cleared("midcount_reset");
        i_reset = 1'b1;
        repeat (1024) sym(1'b0, 1'b0, 2);
        @(negedge clk);
        check("relock",     64'(bus.o_locked),  64'd1);
        check("relock_lat", 64'(bus.o_latency), 64'd7);

        // Sampling the wrong phase sees random data: search keeps stepping.
        @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        i_reset = 1'b1;
        bus.i_phase_sel = 2'd0;
        repeat (2048) sym(1'b0, 1'b1, 2);
        @(negedge clk);
        check("misphase_no_lock", 64'(bus.o_locked), 64'd0);
        check("misphase_delay",   64'(dut.delay),    64'd16);

`ifdef RX_BER_AUTO_RELOCK_EN
        @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        i_reset = 1'b1;
        bus.i_phase_sel = 2'd2;
        dly = 7;
        repeat (1024) sym(1'b0, 1'b0, 2);
        repeat (128) sym(1'b0, 1'b0, 2);
        @(negedge clk);
        check("ar_locked",  64'(bus.o_locked), 64'd1);
        check("ar_bits128", bus.o_bit_count,   64'd128);
        dly   = 9;
        e_exp = 64'd0;
        repeat (128) begin
            sym(1'b0, 1'b0, 2);
            e_exp += 64'(tdl[9] ^ tdl[7]);
        end
        @(negedge clk);
        check("ar_dropped", 64'(bus.o_locked), 64'd0);
        check("ar_bits256", bus.o_bit_count,   64'd256);
        check("ar_errs",    bus.o_err_count,   e_exp);
        repeat (256) sym(1'b0, 1'b0, 2);
        @(negedge clk);
        check("ar_relocked",  64'(bus.o_locked),  64'd1);
        check("ar_latency_9", 64'(bus.o_latency), 64'd9);
        check("ar_bits_kept", bus.o_bit_count,    64'd256);
        check("ar_errs_kept", bus.o_err_count,    e_exp);
`else
        e_exp = 64'd0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
